// File: rtl/map_ctrl_pkg.sv
// Shared constants and types for the tile-map controller.
// Playfield geometry, tile codes and controller states.
package map_pkg;

  localparam int MAP_W    = 20;
  localparam int MAP_H    = 15;
  localparam int MAP_SIZE = MAP_W * MAP_H;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;
  localparam logic [2:0] TILE_BRICK = 3'd2;
  localparam logic [2:0] TILE_BOMB  = 3'd3;
  localparam logic [2:0] TILE_FIRE  = 3'd4;

  typedef enum logic {
    LOAD,
    READY
  } state_t;

endpackage

// File: rtl/map_ctrl_if.sv
// Game-logic access port: two requesters sharing one r/w port.
// Master side drives requests, slave side returns ack/rdata.
interface map_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int TILE_W = 3
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [TILE_W-1:0] wdata0;
  logic [TILE_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [TILE_W-1:0] rdata;

  modport master (
    output req, we, addr0, addr1,
    output wdata0, wdata1,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr0, addr1,
    input  wdata0, wdata1,
    output ack, rdata
  );

endinterface

// File: rtl/map_ctrl_ram.sv
// Map store: one sync r/w port (loader/arbiter), one sync read port (VGA).
// Out-of-range reads return 0 and out-of-range writes are dropped.
module map_ram #(
  parameter int DEPTH  = 300,
  parameter int ADDR_W = 9,
  parameter int TILE_W = 3
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_a_en,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [TILE_W-1:0] i_a_wdata,
  output logic [TILE_W-1:0] o_a_q,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [TILE_W-1:0] o_b_q
);

  localparam logic [ADDR_W-1:0] L_SIZE =
    ADDR_W'(DEPTH);

  logic [TILE_W-1:0] r_mem [DEPTH];

  logic w_a_ok;
  logic w_b_ok;

  assign w_a_ok = (i_a_addr < L_SIZE);
  assign w_b_ok = (i_b_addr < L_SIZE);

  always_ff @(posedge clk) begin
    if (i_a_en && i_a_we && w_a_ok) begin
      r_mem[i_a_addr] <= i_a_wdata;
    end
  end

  // Nonblocking reads give read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_a_q <= '0;
      o_b_q <= '0;
    end else begin
      o_b_q <= w_b_ok ? r_mem[i_b_addr] : '0;
      if (i_a_en && !i_a_we) begin
        o_a_q <= w_a_ok ? r_mem[i_a_addr] : '0;
      end
    end
  end

endmodule

// File: rtl/map_ctrl.sv
// Tile-map controller: ROM load FSM, round-robin game port arbiter,
// and a never-stalled VGA read port over the shared map store.
module map_ctrl
  import map_pkg::*;
#(
  parameter int MAP_SIZE = 300,
  parameter int ADDR_W   = 9,
  parameter int TILE_W   = 3
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TILE_W-1:0] rom_q,
  output logic              map_ready,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [TILE_W-1:0] vga_q,
  map_ctrl_if.slave         gp
);

  localparam logic [ADDR_W-1:0] L_LAST =
    ADDR_W'(MAP_SIZE - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [1:0]        r_ack;
  logic              r_last;

  logic [1:0]        w_elig;
  logic [1:0]        w_gnt;
  logic              w_a_en;
  logic              w_a_we;
  logic [ADDR_W-1:0] w_a_addr;
  logic [TILE_W-1:0] w_a_wdata;
  logic [TILE_W-1:0] w_a_q;

  assign map_ready = (r_state == READY);
  assign gp.ack    = r_ack;
  assign gp.rdata  = w_a_q;

  always_comb begin
    w_next    = r_state;
    w_gnt     = '0;
    w_elig    = gp.req & ~r_ack;
    w_a_en    = 1'b0;
    w_a_we    = 1'b0;
    w_a_addr  = '0;
    w_a_wdata = '0;
    rom_addr  = '0;
    unique case (r_state)
      LOAD: begin
        rom_addr  = r_cnt;
        w_a_en    = 1'b1;
        w_a_we    = 1'b1;
        w_a_addr  = r_cnt;
        w_a_wdata = rom_q;
        if (r_cnt == L_LAST) begin
          w_next = READY;
        end
      end
      READY: begin
        // A restart in the same cycle cancels the grant.
        if (!restart) begin
          if (&w_elig) begin
            w_gnt = r_last ? 2'b01 : 2'b10;
          end else begin
            w_gnt = w_elig;
          end
        end
        unique case (1'b1)
          w_gnt[0]: begin
            w_a_en    = 1'b1;
            w_a_we    = gp.we[0];
            w_a_addr  = gp.addr0;
            w_a_wdata = gp.wdata0;
          end
          w_gnt[1]: begin
            w_a_en    = 1'b1;
            w_a_we    = gp.we[1];
            w_a_addr  = gp.addr1;
            w_a_wdata = gp.wdata1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (restart) begin
      w_next = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_ack   <= w_gnt;
      if (|w_gnt) begin
        r_last <= w_gnt[1];
      end
      if (restart || r_state != LOAD) begin
        r_cnt <= '0;
      end else if (r_cnt == L_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  map_ram #(
    .DEPTH  (MAP_SIZE),
    .ADDR_W (ADDR_W),
    .TILE_W (TILE_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_en    (w_a_en),
    .i_a_we    (w_a_we),
    .i_a_addr  (w_a_addr),
    .i_a_wdata (w_a_wdata),
    .o_a_q     (w_a_q),
    .i_b_addr  (vga_addr),
    .o_b_q     (vga_q)
  );

endmodule

// File: tb/tb_map_ctrl.sv
// Directed scoreboard bench for map_ctrl: ROM load, VGA port,
// arbitration, out-of-range access, restart and mid-load reset.
module tb_map_ctrl;
  import map_pkg::*;

  typedef struct packed {
    logic       idx;
    logic       rd;
    logic [2:0] data;
    int         cyc;
    int         tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic [8:0] rom_addr;
  logic [2:0] rom_q;
  logic       map_ready;
  logic [8:0] vga_addr;
  logic [2:0] vga_q;

  map_ctrl_if gp ();

  exp_t sb[$];
  exp_t e_mon;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   tagn = 0;

  map_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .map_ready (map_ready),
    .vga_addr  (vga_addr),
    .vga_q     (vga_q),
    .gp        (gp)
  );

  always #5 clk = ~clk;

  // Border walls on top/bottom rows except col 19, one brick at 150.
  function automatic logic [2:0] rom_fn(logic [8:0] a);
    int r = int'(a) / 20;
    int c = int'(a) % 20;
    if ((r == 0 || r == 14) && c != 19) return TILE_WALL;
    if (a == 9'd150) return TILE_BRICK;
    return TILE_EMPTY;
  endfunction

  assign rom_q = rom_fn(rom_addr);

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && gp.ack != 2'b00) begin
      nvec++;
      if (gp.ack == 2'b11) begin
        nerr++;
        $display("FAIL ack_both: ack=%b, required one-hot", gp.ack);
      end else if (sb.size() == 0) begin
        nerr++;
        $display("FAIL ack_unexpected: ack=%b at cycle %0d, required none",
                 gp.ack, cyc);
      end else begin
        e_mon = sb.pop_front();
        if (gp.ack != (2'b01 << e_mon.idx) || cyc != e_mon.cyc ||
            (e_mon.rd && gp.rdata != e_mon.data)) begin
          nerr++;
          $display("FAIL ack_t%0d: ack=%b cyc=%0d rdata=%0d, required ack bit %0d cyc=%0d rdata=%0d",
                   e_mon.tag, gp.ack, cyc, gp.rdata, e_mon.idx,
                   e_mon.cyc, e_mon.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input bit rd, input logic [2:0] d,
                      input int at);
    sb.push_back('{idx: i[0], rd: rd, data: d, cyc: at, tag: tagn});
    tagn++;
  endtask

  task automatic access(input int i, input bit w, input logic [8:0] a,
                        input logic [2:0] d, input logic [2:0] exp);
    bit got = 1'b0;
    step();
    if (i == 0) begin
      gp.we[0] = w; gp.addr0 = a; gp.wdata0 = d; gp.req[0] = 1'b1;
    end else begin
      gp.we[1] = w; gp.addr1 = a; gp.wdata1 = d; gp.req[1] = 1'b1;
    end
    push(i, !w, exp, cyc + 1);
    for (int k = 0; k < 20; k++) begin
      step();
      if (gp.ack[i]) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_wait", int'(got), 1);
    gp.req[i] = 1'b0;
    gp.we[i]  = 1'b0;
  endtask

  task automatic vga_chk(input string nm, input logic [8:0] a,
                         input int exp);
    vga_addr = a;
    step();
    chk(nm, vga_q, exp);
  endtask

  task automatic reset_chk();
    chk("rst_ready", map_ready, 0);
    chk("rst_ack", gp.ack, 0);
    chk("rst_rdata", gp.rdata, 0);
    chk("rst_vga_q", vga_q, 0);
    chk("rst_rom_addr", rom_addr, 0);
  endtask

  task automatic wait_load(input int mode);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1)   chk("load_rom_addr1", rom_addr, 1);
      if (k == 299) chk("ready_at_299", map_ready, 0);
      if (mode == 1 && k == 5) begin
        gp.we[0] = 1'b0; gp.addr0 = 9'd0; gp.req[0] = 1'b1;
        push(0, 1'b1, 3'd1, cyc + 296);
      end
      if (mode == 2 && k == 2) vga_addr = 9'd22;
      if (mode == 2 && k == 3) chk("vga_during_load", vga_q, 2);
    end
    chk("ready_at_300", map_ready, 1);
    chk("ready_rom_addr", rom_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; restart = 1'b0; vga_addr = '0;
    gp.req = '0; gp.we = '0; gp.addr0 = '0; gp.addr1 = '0;
    gp.wdata0 = '0; gp.wdata1 = '0;
    repeat (3) step();
    reset_chk();
    rst_n = 1'b1;

    // Initial load with a player request pending from cycle 5.
    wait_load(1);
    step();
    gp.req[0] = 1'b0;

    vga_chk("vga_0", 9'd0, 1);
    vga_chk("vga_21", 9'd21, 0);
    vga_chk("vga_281", 9'd281, 1);
    vga_chk("vga_299", 9'd299, 0);
    vga_chk("vga_150", 9'd150, 2);

    // Bomb write to 22 with a same-cycle VGA read of 22.
    step();
    gp.we[1] = 1'b1; gp.addr1 = 9'd22; gp.wdata1 = 3'd2;
    gp.req[1] = 1'b1; vga_addr = 9'd22;
    push(1, 1'b0, 3'd0, cyc + 1);
    step();
    chk("vga_rbw_old", vga_q, 0);
    gp.req[1] = 1'b0; gp.we[1] = 1'b0;
    step();
    chk("vga_22_new", vga_q, 2);

    access(0, 1'b0, 9'd22, 3'd0, 3'd2);
    access(1, 1'b0, 9'd150, 3'd0, 3'd2);

    // Contention: both reading, pointer last on bomb unit.
    step();
    gp.we = 2'b00; gp.addr0 = 9'd0; gp.addr1 = 9'd150;
    gp.req = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 1) push(0, 1'b1, 3'd1, cyc + k);
      else            push(1, 1'b1, 3'd2, cyc + k);
    end
    repeat (6) step();
    gp.req = 2'b00;

    access(0, 1'b1, 9'd300, 3'd5, 3'd0);
    access(0, 1'b0, 9'd300, 3'd0, 3'd0);
    access(1, 1'b0, 9'd511, 3'd0, 3'd0);
    vga_chk("vga_299_kept", 9'd299, 0);
    vga_chk("vga_300", 9'd300, 0);

    // Restart with a same-cycle grant that must be cancelled.
    step();
    restart = 1'b1;
    gp.we[0] = 1'b0; gp.addr0 = 9'd0; gp.req[0] = 1'b1;
    step();
    restart = 1'b0;
    gp.req[0] = 1'b0;
    chk("restart_ready", map_ready, 0);
    chk("restart_noack", gp.ack, 0);
    wait_load(2);
    vga_chk("vga_22_reload", 9'd22, 0);
    access(0, 1'b0, 9'd0, 3'd0, 3'd1);
    vga_addr = 9'd0;

    // Second restart, then reset at load cycle 150.
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (150) step();
    chk("load_mid_addr", rom_addr, 150);
    rst_n = 1'b0;
    repeat (2) step();
    reset_chk();
    rst_n = 1'b1;
    wait_load(0);
    vga_chk("vga_0_final", 9'd0, 1);
    vga_chk("vga_22_final", 9'd22, 0);

    repeat (3) step();
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
